axi_full_burst_master: RTL

// Command-driven AXI4 full master. Successor to the fixed-pattern burst master, generalised in width and burst length.
// The user issues per-command addresses and lengths, streams write data in and read data out, and receives completion status.

---
 rtl/axi_full_burst_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_full_burst_master.sv
// axi_full_burst_master: command-driven AXI4 burst master with independent write and read channels
module axi_full_burst_master #(
   parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h80000000,
   parameter int          C_M_AXI_ID_WIDTH           = 1,
   parameter int          C_M_AXI_ADDR_WIDTH         = 32,
   parameter int          C_M_AXI_DATA_WIDTH         = 32,
   parameter int          C_MAX_BURST_LEN            = 16
) (
   input  logic                              i_m_axi_aclk,
   input  logic                              i_m_axi_areset,
   input  logic                              i_wr_cmd_valid,
   output logic                              o_wr_cmd_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_wr_cmd_addr,
   input  logic [7:0]                        i_wr_cmd_len,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_wr_data,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   i_wr_strb,
   input  logic                              i_wr_data_valid,
   output logic                              o_wr_data_ready,
   output logic                              o_wr_done,
   output logic [1:0]                        o_wr_resp,
   input  logic                              i_rd_cmd_valid,
   output logic                              o_rd_cmd_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_rd_cmd_addr,
   input  logic [7:0]                        i_rd_cmd_len,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     o_rd_data,
   output logic                              o_rd_data_last,
   output logic                              o_rd_data_valid,
   input  logic                              i_rd_data_ready,
   output logic                              o_rd_done,
   output logic [1:0]                        o_rd_resp,
   output logic                              o_m_axi_awvalid,
   input  logic                              i_m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     o_m_axi_awaddr,
   output logic [C_M_AXI_ID_WIDTH-1:0]       o_m_axi_awid,
   output logic [7:0]                        o_m_axi_awlen,
   output logic [2:0]                        o_m_axi_awsize,
   output logic [1:0]                        o_m_axi_awburst,
   output logic                              o_m_axi_wvalid,
   input  logic                              i_m_axi_wready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     o_m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   o_m_axi_wstrb,
   output logic                              o_m_axi_wlast,
   input  logic                              i_m_axi_bvalid,
   output logic                              o_m_axi_bready,
   input  logic [1:0]                        i_m_axi_bresp,
   input  logic [C_M_AXI_ID_WIDTH-1:0]       i_m_axi_bid,
   output logic                              o_m_axi_arvalid,
   input  logic                              i_m_axi_arready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     o_m_axi_araddr,
   output logic [C_M_AXI_ID_WIDTH-1:0]       o_m_axi_arid,
   output logic [7:0]                        o_m_axi_arlen,
   output logic [2:0]                        o_m_axi_arsize,
   output logic [1:0]                        o_m_axi_arburst,
   input  logic                              i_m_axi_rvalid,
   output logic                              o_m_axi_rready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_m_axi_rdata,
   input  logic [1:0]                        i_m_axi_rresp,
   input  logic                              i_m_axi_rlast,
   input  logic [C_M_AXI_ID_WIDTH-1:0]       i_m_axi_rid
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam logic [AW-1:0] BASE = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
   localparam logic [2:0] SIZE = 3'($clog2(C_M_AXI_DATA_WIDTH/8));
   localparam logic [7:0] LMAX = 8'(C_MAX_BURST_LEN-1);
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   w_state_t        r_w_state, w_w_next;
   r_state_t        r_r_state, w_r_next;
   logic [AW-1:0]   r_aw_addr, r_ar_addr;
   logic [7:0]      r_aw_len, r_ar_len, r_w_cnt, r_r_cnt;
   logic            r_wr_done, r_rd_done, r_r_err;
   logic [1:0]      r_wr_resp, r_rd_resp, r_r_acc;
   logic            w_w_last, w_w_hs, w_r_last, w_r_hs, w_r_bad;
   logic [1:0]      w_r_max;
   logic            w_unused;
   assign w_unused = ^{i_m_axi_bid, i_m_axi_rid};
   assign w_w_last = r_w_cnt == r_aw_len;
   assign w_w_hs   = (r_w_state == W_DATA) & i_wr_data_valid & i_m_axi_wready;
   assign w_r_last = r_r_cnt == r_ar_len;
   assign w_r_hs   = (r_r_state == R_DATA) & i_m_axi_rvalid & i_rd_data_ready;
   assign w_r_max  = (i_m_axi_rresp > r_r_acc) ? i_m_axi_rresp : r_r_acc;
   assign w_r_bad  = r_r_err | (i_m_axi_rlast != w_r_last);

   // write FSM state register
   always_ff @(posedge i_m_axi_aclk)
      r_w_state <= i_m_axi_areset ? W_IDLE : w_w_next;

   // write FSM next state
   always_comb begin
      w_w_next = r_w_state;
      unique case (r_w_state)
         W_IDLE:  w_w_next = i_wr_cmd_valid ? W_ADDR : W_IDLE;
         W_ADDR:  w_w_next = i_m_axi_awready ? W_DATA : W_ADDR;
         W_DATA:  w_w_next = (w_w_hs & w_w_last) ? W_RESP : W_DATA;
         default: w_w_next = i_m_axi_bvalid ? W_IDLE : W_RESP;
      endcase
   end

   // write FSM outputs; stream handshakes only pass through in W_DATA
   always_comb begin
      o_wr_cmd_ready  = (r_w_state == W_IDLE) & ~i_m_axi_areset;
      o_m_axi_awvalid = r_w_state == W_ADDR;
      o_m_axi_wvalid  = (r_w_state == W_DATA) & i_wr_data_valid;
      o_wr_data_ready = (r_w_state == W_DATA) & i_m_axi_wready;
      o_m_axi_wlast   = (r_w_state == W_DATA) & w_w_last;
      o_m_axi_bready  = r_w_state == W_RESP;
      o_m_axi_wdata   = i_wr_data;
      o_m_axi_wstrb   = i_wr_strb;
      o_m_axi_awaddr  = r_aw_addr;
      o_m_axi_awlen   = r_aw_len;
      o_m_axi_awid    = '0;
      o_m_axi_awsize  = SIZE;
      o_m_axi_awburst = 2'b01;
      o_wr_done       = r_wr_done;
      o_wr_resp       = r_wr_resp;
   end

   // write command latch, beat counter and completion status
   always_ff @(posedge i_m_axi_aclk) begin
      if (i_m_axi_areset) begin
         r_aw_addr <= '0;
         r_aw_len  <= '0;
         r_w_cnt   <= '0;
         r_wr_done <= 1'b0;
         r_wr_resp <= 2'b00;
      end else begin
         r_wr_done <= (r_w_state == W_RESP) & i_m_axi_bvalid;
         if ((r_w_state == W_RESP) & i_m_axi_bvalid) r_wr_resp <= i_m_axi_bresp;
         if ((r_w_state == W_IDLE) & i_wr_cmd_valid) begin
            r_aw_addr <= BASE + i_wr_cmd_addr;
            r_aw_len  <= (i_wr_cmd_len > LMAX) ? LMAX : i_wr_cmd_len;
            r_w_cnt   <= '0;
         end else if (w_w_hs) r_w_cnt <= r_w_cnt + 8'd1;
      end
   end

   // read FSM state register
   always_ff @(posedge i_m_axi_aclk)
      r_r_state <= i_m_axi_areset ? R_IDLE : w_r_next;

   // read FSM next state; the burst ends on the local beat count, not RLAST
   always_comb begin
      w_r_next = r_r_state;
      unique case (r_r_state)
         R_IDLE:  w_r_next = i_rd_cmd_valid ? R_ADDR : R_IDLE;
         R_ADDR:  w_r_next = i_m_axi_arready ? R_DATA : R_ADDR;
         default: w_r_next = (w_r_hs & w_r_last) ? R_IDLE : R_DATA;
      endcase
   end

   // read FSM outputs
   always_comb begin
      o_rd_cmd_ready  = (r_r_state == R_IDLE) & ~i_m_axi_areset;
      o_m_axi_arvalid = r_r_state == R_ADDR;
      o_m_axi_rready  = (r_r_state == R_DATA) & i_rd_data_ready;
      o_rd_data_valid = (r_r_state == R_DATA) & i_m_axi_rvalid;
      o_rd_data_last  = (r_r_state == R_DATA) & w_r_last;
      o_rd_data       = i_m_axi_rdata;
      o_m_axi_araddr  = r_ar_addr;
      o_m_axi_arlen   = r_ar_len;
      o_m_axi_arid    = '0;
      o_m_axi_arsize  = SIZE;
      o_m_axi_arburst = 2'b01;
      o_rd_done       = r_rd_done;
      o_rd_resp       = r_rd_resp;
   end

   // read command latch, beat counter, worst-response and RLAST-mismatch tracking
   always_ff @(posedge i_m_axi_aclk) begin
      if (i_m_axi_areset) begin
         r_ar_addr <= '0;
         r_ar_len  <= '0;
         r_r_cnt   <= '0;
         r_r_acc   <= 2'b00;
         r_r_err   <= 1'b0;
         r_rd_done <= 1'b0;
         r_rd_resp <= 2'b00;
      end else begin
         r_rd_done <= w_r_hs & w_r_last;
         if ((r_r_state == R_IDLE) & i_rd_cmd_valid) begin
            r_ar_addr <= BASE + i_rd_cmd_addr;
            r_ar_len  <= (i_rd_cmd_len > LMAX) ? LMAX : i_rd_cmd_len;
         end
         if ((r_r_state == R_ADDR) & i_m_axi_arready) begin
            r_r_cnt <= '0;
            r_r_acc <= 2'b00;
            r_r_err <= 1'b0;
         end else if (w_r_hs) begin
            r_r_cnt <= r_r_cnt + 8'd1;
            r_r_acc <= w_r_max;
            r_r_err <= w_r_bad;
            if (w_r_last) r_rd_resp <= w_r_bad ? 2'b10 : w_r_max;
         end
      end
   end
endmodule
